// File: rtl/secuenciador_teclado_pkg.sv
// Shared scan codes (PS/2 set 2), FSM state encoding and small decode helpers
// for the keyboard command sequencer.
package secuenciador_teclado_pkg;

  localparam logic [7:0] SC_D0    = 8'h45;
  localparam logic [7:0] SC_D1    = 8'h16;
  localparam logic [7:0] SC_D2    = 8'h1E;
  localparam logic [7:0] SC_D3    = 8'h26;
  localparam logic [7:0] SC_D4    = 8'h25;
  localparam logic [7:0] SC_D5    = 8'h2E;
  localparam logic [7:0] SC_D6    = 8'h36;
  localparam logic [7:0] SC_D7    = 8'h3D;
  localparam logic [7:0] SC_D8    = 8'h3E;
  localparam logic [7:0] SC_D9    = 8'h46;
  localparam logic [7:0] SC_T     = 8'h2C;
  localparam logic [7:0] SC_P     = 8'h4D;
  localparam logic [7:0] SC_C     = 8'h21;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EDIT    = 2'd1,
    ST_TEMP_D1 = 2'd2,
    ST_TEMP_D2 = 2'd3
  } estado_t;

  // Returns {valid, value[3:0]}; valid=0 for any non-digit code.
  function automatic logic [4:0] decodifica_digito(input logic [7:0] codigo);
    logic [4:0] r;
    r = 5'd0;
    case (codigo)
      SC_D0:   r = {1'b1, 4'd0};
      SC_D1:   r = {1'b1, 4'd1};
      SC_D2:   r = {1'b1, 4'd2};
      SC_D3:   r = {1'b1, 4'd3};
      SC_D4:   r = {1'b1, 4'd4};
      SC_D5:   r = {1'b1, 4'd5};
      SC_D6:   r = {1'b1, 4'd6};
      SC_D7:   r = {1'b1, 4'd7};
      SC_D8:   r = {1'b1, 4'd8};
      SC_D9:   r = {1'b1, 4'd9};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  function automatic logic [4:0] satura_temp(input logic [6:0] valor, input logic [6:0] tope);
    logic [6:0] r;
    r = (valor > tope) ? tope : valor;
    return r[4:0];
  endfunction

endpackage

// File: rtl/secuenciador_teclado_temporizador.sv
// Inactivity timer: counts enabled cycles since the last clear and flags the
// cycle on which CICLOS-1 is reached. A clear in that same cycle suppresses expiry.
module secuenciador_teclado_temporizador #(
  parameter int CICLOS = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expira
);

  localparam int W = (CICLOS > 2) ? $clog2(CICLOS) : 1;
  localparam logic [W-1:0] ULTIMO = W'(CICLOS - 1);

  logic [W-1:0] cnt;

  assign expira = en && !clr && (cnt == ULTIMO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= expira ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/secuenciador_teclado.sv
// Keyboard command sequencer: filters PS/2 bytes, edits staged temperature /
// presence / car values and publishes them atomically on Enter.
module secuenciador_teclado
  import secuenciador_teclado_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int TEMP_MAX    = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] Dato,
  input  logic       Tick,
  output logic [4:0] Temp,
  output logic       Presencia,
  output logic       Carro,
  output logic       active,
  output logic       busy,
  output logic       err
);

  localparam logic [6:0] TOPE = 7'(TEMP_MAX);

  estado_t    state;
  logic       skip;
  logic [4:0] stg_temp;
  logic       stg_pres;
  logic       stg_car;
  logic [3:0] tens;
  logic       expira;

  // A key opened from IDLE starts from the committed values, not stale staging.
  logic [4:0] base_temp;
  logic       base_pres;
  logic       base_car;
  assign base_temp = (state == ST_IDLE) ? Temp      : stg_temp;
  assign base_pres = (state == ST_IDLE) ? Presencia : stg_pres;
  assign base_car  = (state == ST_IDLE) ? Carro     : stg_car;

  logic [4:0] digito;
  logic       dig_ok;
  logic [3:0] dig_val;
  assign digito  = decodifica_digito(Dato);
  assign dig_ok  = digito[4];
  assign dig_val = digito[3:0];

  logic [6:0] suma;
  logic [4:0] temp_dos;
  logic [4:0] temp_uno;
  assign suma     = ({3'b000, tens} * 7'd10) + {3'b000, dig_val};
  assign temp_dos = satura_temp(suma, TOPE);
  assign temp_uno = satura_temp({3'b000, tens}, TOPE);

  assign busy = (state != ST_IDLE);

  secuenciador_teclado_temporizador #(
    .CICLOS (TIMEOUT_CYC)
  ) u_temporizador_inactividad (
    .clk    (clk),
    .rst    (rst),
    .clr    (Tick || (state == ST_IDLE)),
    .en     (busy),
    .expira (expira)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      skip      <= 1'b0;
      stg_temp  <= 5'd0;
      stg_pres  <= 1'b0;
      stg_car   <= 1'b0;
      tens      <= 4'd0;
      Temp      <= 5'd0;
      Presencia <= 1'b0;
      Carro     <= 1'b0;
      active    <= 1'b0;
      err       <= 1'b0;
    end else begin
      active <= 1'b0;
      err    <= 1'b0;
      if (Tick) begin
        if (Dato == SC_BREAK || Dato == SC_EXT) begin
          skip <= 1'b1;
        end else if (skip) begin
          skip <= 1'b0;
        end else begin
          stg_temp <= base_temp;
          stg_pres <= base_pres;
          stg_car  <= base_car;
          case (state)
            ST_IDLE, ST_EDIT: begin
              if (Dato == SC_T) begin
                state <= ST_TEMP_D1;
              end else if (Dato == SC_P) begin
                stg_pres <= !base_pres;
                state    <= ST_EDIT;
              end else if (Dato == SC_C) begin
                stg_car <= !base_car;
                state   <= ST_EDIT;
              end else if (Dato == SC_ENTER) begin
                Temp      <= base_temp;
                Presencia <= base_pres;
                Carro     <= base_car;
                active    <= 1'b1;
                state     <= ST_IDLE;
              end else if (Dato == SC_ESC) begin
                state <= ST_IDLE;
              end else begin
                err   <= 1'b1;
                state <= ST_EDIT;
              end
            end
            ST_TEMP_D1: begin
              if (dig_ok) begin
                tens  <= dig_val;
                state <= ST_TEMP_D2;
              end else if (Dato == SC_ENTER) begin
                Temp      <= base_temp;
                Presencia <= base_pres;
                Carro     <= base_car;
                active    <= 1'b1;
                state     <= ST_IDLE;
              end else if (Dato == SC_ESC) begin
                state <= ST_EDIT;
              end else begin
                err   <= 1'b1;
                state <= ST_EDIT;
              end
            end
            ST_TEMP_D2: begin
              if (dig_ok) begin
                stg_temp <= temp_dos;
                state    <= ST_EDIT;
              end else if (Dato == SC_ENTER) begin
                // A single digit followed by Enter is taken as the full value.
                Temp      <= temp_uno;
                Presencia <= base_pres;
                Carro     <= base_car;
                active    <= 1'b1;
                state     <= ST_IDLE;
              end else if (Dato == SC_ESC) begin
                state <= ST_EDIT;
              end else begin
                err   <= 1'b1;
                state <= ST_EDIT;
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
      end else if (expira) begin
        err   <= 1'b1;
        state <= ST_IDLE;
        skip  <= 1'b0;
      end
    end
  end

endmodule
